slv_wr_scheduler: RTL and testbench
===================================

Name: slv_wr_scheduler

Overview:
- Shares one AXI slave write port (AW + W) between NB_REQ requesters. Used in the test bench to put several master drivers in front of a single slv_monitor.
- AW: round-robin arbitration with grant lock while the output is stalled.
- W: each granted requester index is queued in order. W beats are routed from the queue head until its wlast beat completes.
- B is not handled here; the bench routes B by ID.

Parameters:
- NB_REQ, 4, number of requesters, 2..8.
- AW_PLD_W, 32, width of the opaque AW payload ({awid, awaddr, awlen, ...}), forwarded unchanged.
- W_PLD_W, 40, width of the opaque W payload ({wdata, wstrb}), forwarded unchanged.
- GNT_FIFO_DEPTH_W, 2, log2 depth of the grant-order FIFO. It bounds how many AW grants can be outstanding without completed W bursts.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- srst  in  1  synchronous clear, active high; same effect as aresetn.
- s_awvalid  in  NB_REQ  per-requester AW valid.
- s_awready  out  NB_REQ  per-requester AW ready.
- s_awpld  in  NB_REQ*AW_PLD_W  AW payloads; requester i occupies slice [i*AW_PLD_W +: AW_PLD_W].
- s_wvalid  in  NB_REQ  per-requester W valid.
- s_wready  out  NB_REQ  per-requester W ready.
- s_wlast  in  NB_REQ  per-requester W last.
- s_wpld  in  NB_REQ*W_PLD_W  W payloads, sliced as for AW.
- m_awvalid  out  1  AW valid to slave.
- m_awready  in  1  AW ready from slave.
- m_awpld  out  AW_PLD_W  selected AW payload.
- m_wvalid  out  1  W valid to slave.
- m_wready  in  1  W ready from slave.
- m_wlast  out  1  selected W last.
- m_wpld  out  W_PLD_W  selected W payload.
- m_wsel  out  clog2(NB_REQ)  index of the current W owner; debug only.

Behaviour:
- Reset (aresetn low, or srst high at a clock edge):
  - rr pointer = 0 (requester 0 has highest priority).
  - Grant lock cleared; grant FIFO emptied.
  - All outputs are combinationally 0 while empty and unlocked: m_awvalid, m_wvalid, s_awready, s_wready, m_wlast, m_wsel.
- AW arbitration:
  - req = s_awvalid, masked to zero when the FIFO is full.
  - Unlocked: grant is one-hot, the first set req bit at or after the pointer (circular scan). Combinational, zero-cycle latency.
  - m_awvalid = |req. m_awpld = payload of the granted requester.
  - s_awready[i] = grant[i] & m_awready & ~full.
- Grant lock:
  - Set at the edge where m_awvalid & ~m_awready.
  - While locked, grant holds the registered value regardless of other requests, so m_awvalid and m_awpld stay stable as AXI requires.
  - Cleared on the m_awvalid & m_awready handshake.
- On AW handshake:
  - Push the grant index into the FIFO.
  - Pointer <= (index+1) mod NB_REQ.
- Pointer wrap: index NB_REQ-1 wraps the pointer to 0.
- FIFO full: no new AW is presented (m_awvalid = 0). A pop in the same cycle does not unblock AW until the next cycle.
- W routing:
  - head = FIFO output.
  - m_wvalid = ~empty & s_wvalid[head].
  - s_wready[i] = ~empty & (head==i) & m_wready.
  - m_wpld and m_wlast come from the head requester; m_wsel = head.
- W pop: on m_wvalid & m_wready & m_wlast; the next head is usable the following cycle.
- FIFO timing:
  - Not pass-thru: the earliest first W beat is the cycle after its AW handshake.
  - Simultaneous push and pop is allowed; the count is unchanged.
- W from non-head requesters is stalled (s_wready = 0) and must not leak to m_w*.
- W wait state: m_wvalid is 0 while the head requester's s_wvalid is low. The head is held until that burst's wlast completes.
- Reset mid-burst: FIFO and lock are dropped at once. Partial bursts are abandoned; requesters must be reset together with the block.
- Starvation bound: a continuously requesting requester is granted within NB_REQ AW handshakes.

Decomposition:
- Shared package (slv_wr_sched_pkg):
  - Function rr_pick(req, ptr) returning a one-hot grant.
  - Index-width constant IDX_W = clog2(NB_REQ), via the existing functions.sv helpers.
- Sub-module: the grant FIFO is an instance of the existing axicb_scfifo with:
  - PASS_THRU=0, ADDR_WIDTH=GNT_FIFO_DEPTH_W, DATA_WIDTH=IDX_W, flush=0.
- No other sub-module.

Test Plan:
- Single requester 2 issues AW (awlen=3) then 4 W beats, m_awready=m_wready=1 -> AW passes in the same cycle; W beats appear from the next cycle with m_wsel=2; wlast pops the FIFO; pointer=3.
- All 4 requesters assert AW continuously, m_awready=1, bursts of 1 beat each -> grant order 0,1,2,3,0; each W beat follows its own grant order.
- Req 1 AW while m_awready=0 for 3 cycles, req 0 raises awvalid in cycle 2 -> m_awpld stays req 1 payload for all 3 cycles; req 1 granted when m_awready rises; req 0 next.
- GNT_FIFO_DEPTH_W=2, m_wready=0, 5 AW requests -> exactly 4 AW handshakes and m_awvalid=0 afterwards; a single wlast beat allows the 5th AW the following cycle.
- Req 3 drives W before its AW while the head is req 0 mid-burst -> s_wready[3]=0; no req 3 data on m_wpld until req 0 wlast completes and req 3 is head.
- aresetn pulsed low during a 4-beat burst at beat 2 -> all outputs 0 immediately; after release, pointer=0 and FIFO empty; new traffic starts cleanly.

Source files
------------

// File: rtl/slv_wr_sched_pkg.sv
// Shared helpers for the write-port scheduler: index width and the
// round-robin pick / one-hot encode used by AW arbitration.
package slv_wr_sched_pkg;

    localparam int unsigned MAX_REQ   = 8;
    localparam int unsigned MAX_IDX_W = 3;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // First set req bit at or after ptr, scanning circularly over n requesters.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0]   req,
                                                   input logic [MAX_IDX_W-1:0] ptr,
                                                   input int unsigned          n);
        logic [MAX_REQ-1:0]   gnt;
        logic [MAX_IDX_W-1:0] pos;
        logic                 found;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            pos = MAX_IDX_W'((32'(ptr) + k) % n);
            if ((k < n) && !found && req[pos]) begin
                gnt[pos] = 1'b1;
                found    = 1'b1;
            end
        end
        return gnt;
    endfunction

    function automatic logic [MAX_IDX_W-1:0] oh2idx(input logic [MAX_REQ-1:0] oh);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = idx | MAX_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/slv_wr_scheduler_if.sv
// Requester-side and slave-side AW/W signals of the shared write port.
interface slv_wr_scheduler_if
    import slv_wr_sched_pkg::*;
#(
    parameter int unsigned NB_REQ   = 4,
    parameter int unsigned AW_PLD_W = 32,
    parameter int unsigned W_PLD_W  = 40,
    parameter int unsigned IDX_W    = idx_width(NB_REQ)
);

    logic [NB_REQ-1:0]          s_awvalid;
    logic [NB_REQ-1:0]          s_awready;
    logic [NB_REQ*AW_PLD_W-1:0] s_awpld;
    logic [NB_REQ-1:0]          s_wvalid;
    logic [NB_REQ-1:0]          s_wready;
    logic [NB_REQ-1:0]          s_wlast;
    logic [NB_REQ*W_PLD_W-1:0]  s_wpld;

    logic                       m_awvalid;
    logic                       m_awready;
    logic [AW_PLD_W-1:0]        m_awpld;
    logic                       m_wvalid;
    logic                       m_wready;
    logic                       m_wlast;
    logic [W_PLD_W-1:0]         m_wpld;
    logic [IDX_W-1:0]           m_wsel;

    // Scheduler view.
    modport slave (
        input  s_awvalid, s_awpld, s_wvalid, s_wlast, s_wpld, m_awready, m_wready,
        output s_awready, s_wready, m_awvalid, m_awpld, m_wvalid, m_wlast, m_wpld, m_wsel
    );

    // Requesters plus downstream slave view.
    modport master (
        output s_awvalid, s_awpld, s_wvalid, s_wlast, s_wpld, m_awready, m_wready,
        input  s_awready, s_wready, m_awvalid, m_awpld, m_wvalid, m_wlast, m_wpld, m_wsel
    );

endinterface

// File: rtl/axicb_scfifo.sv
// Single-clock FIFO with optional pass-through when empty.
module axicb_scfifo #(
    parameter int unsigned PASS_THRU  = 0,
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned DATA_WIDTH = 2
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  srst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  push,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  pop,
    output logic                  empty
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  store_empty, bypass, wr_en, rd_en;

    assign store_empty = (cnt_q == '0);
    assign full        = (cnt_q == CW'(DEPTH));
    assign bypass      = (PASS_THRU != 0) && store_empty && push;
    assign empty       = store_empty & ~bypass;
    assign data_out    = bypass ? data_in : mem[rd_q];
    assign wr_en       = push & ~full & ~(bypass & pop);
    assign rd_en       = pop & ~store_empty;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (wr_en) wr_d = wr_q + ADDR_WIDTH'(1);
        if (rd_en) rd_d = rd_q + ADDR_WIDTH'(1);
        if (wr_en && !rd_en) cnt_d = cnt_q + CW'(1);
        if (!wr_en && rd_en) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (srst || flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: reads are qualified by the count.
    always_ff @(posedge aclk) begin
        if (wr_en) mem[wr_q] <= data_in;
    end

endmodule

// File: rtl/slv_wr_scheduler.sv
// Shares one AXI slave AW+W port among NB_REQ requesters: round-robin AW with
// grant lock under backpressure, W routed in AW grant order via a small FIFO.
module slv_wr_scheduler
    import slv_wr_sched_pkg::*;
#(
    parameter int unsigned NB_REQ           = 4,
    parameter int unsigned AW_PLD_W         = 32,
    parameter int unsigned W_PLD_W          = 40,
    parameter int unsigned GNT_FIFO_DEPTH_W = 2
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              srst,
    slv_wr_scheduler_if.slave bus
);

    localparam int unsigned IDX_W = idx_width(NB_REQ);

    logic [NB_REQ-1:0]   req, gnt_rr, gnt, gnt_q, gnt_d;
    logic                lock_q, lock_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d, gnt_idx, head;
    logic                fifo_full, fifo_empty;
    logic                aw_valid, aw_hs, w_valid, w_pop;
    logic [AW_PLD_W-1:0] aw_pld;
    logic [NB_REQ-1:0]   w_rdy;

    // AW arbitration: locked grant overrides the round-robin pick.
    assign req      = bus.s_awvalid & {NB_REQ{~fifo_full}};
    assign gnt_rr   = NB_REQ'(rr_pick(MAX_REQ'(req), MAX_IDX_W'(ptr_q), NB_REQ));
    assign gnt      = lock_q ? gnt_q : gnt_rr;
    assign gnt_idx  = IDX_W'(oh2idx(MAX_REQ'(gnt)));
    assign aw_valid = |(gnt & req);
    assign aw_hs    = aw_valid & bus.m_awready;

    always_comb begin
        aw_pld = '0;
        for (int unsigned i = 0; i < NB_REQ; i++) begin
            if (gnt[i]) aw_pld = aw_pld | bus.s_awpld[i*AW_PLD_W +: AW_PLD_W];
        end
    end

    assign bus.m_awvalid = aw_valid;
    assign bus.m_awpld   = aw_pld;
    assign bus.s_awready = gnt & {NB_REQ{bus.m_awready & ~fifo_full}};

    always_comb begin
        lock_d = lock_q;
        gnt_d  = gnt_q;
        ptr_d  = ptr_q;
        if (aw_hs) begin
            lock_d = 1'b0;
            ptr_d  = (gnt_idx == IDX_W'(NB_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
        end else if (aw_valid) begin
            lock_d = 1'b1;
            gnt_d  = gnt;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            lock_q <= 1'b0;
            gnt_q  <= '0;
            ptr_q  <= '0;
        end else if (srst) begin
            lock_q <= 1'b0;
            gnt_q  <= '0;
            ptr_q  <= '0;
        end else begin
            lock_q <= lock_d;
            gnt_q  <= gnt_d;
            ptr_q  <= ptr_d;
        end
    end

    axicb_scfifo #(
        .PASS_THRU  (0),
        .ADDR_WIDTH (GNT_FIFO_DEPTH_W),
        .DATA_WIDTH (IDX_W)
    ) u_gnt_fifo (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .srst     (srst),
        .flush    (1'b0),
        .data_in  (gnt_idx),
        .push     (aw_hs),
        .full     (fifo_full),
        .data_out (head),
        .pop      (w_pop),
        .empty    (fifo_empty)
    );

    // W routing from the FIFO head; everything is gated off while empty.
    assign w_valid = ~fifo_empty & bus.s_wvalid[head];
    assign w_pop   = w_valid & bus.m_wready & bus.s_wlast[head];

    always_comb begin
        w_rdy = '0;
        for (int unsigned i = 0; i < NB_REQ; i++) begin
            w_rdy[i] = ~fifo_empty & (head == IDX_W'(i)) & bus.m_wready;
        end
    end

    assign bus.s_wready = w_rdy;
    assign bus.m_wvalid = w_valid;
    assign bus.m_wlast  = ~fifo_empty & bus.s_wlast[head];
    assign bus.m_wpld   = fifo_empty ? '0 : bus.s_wpld[head*W_PLD_W +: W_PLD_W];
    assign bus.m_wsel   = fifo_empty ? '0 : head;

endmodule

// File: tb/tb_slv_wr_scheduler.sv
// Directed bench for slv_wr_scheduler: per-requester source queues drive the
// ports, expected AW/W traffic is scoreboarded in predicted grant order.
module tb_slv_wr_scheduler;

    localparam int unsigned NB    = 4;
    localparam int unsigned AWW   = 32;
    localparam int unsigned WW    = 40;
    localparam int unsigned DW    = 2;
    localparam int unsigned IW    = 2;
    localparam int unsigned EW    = IW + 1 + WW;

    logic aclk;
    logic aresetn;
    logic srst;

    slv_wr_scheduler_if #(.NB_REQ(NB), .AW_PLD_W(AWW), .W_PLD_W(WW)) bus ();

    slv_wr_scheduler #(
        .NB_REQ(NB), .AW_PLD_W(AWW), .W_PLD_W(WW), .GNT_FIFO_DEPTH_W(DW)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .srst    (srst),
        .bus     (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int vectors = 0;
    int errors  = 0;
    int aw_hs_cnt = 0;

    logic [AWW-1:0] aw_src [NB][$];
    logic [WW:0]    w_src  [NB][$];
    logic [AWW-1:0] exp_aw [$];
    logic [EW-1:0]  exp_w  [$];
    logic [NB-1:0]  aw_en;
    logic [NB-1:0]  w_en;

    function automatic logic [AWW-1:0] aw_pld(input int r, input int tag, input int n);
        return {8'(r), 8'(tag), 8'(n - 1), 8'hA5};
    endfunction

    function automatic logic [WW-1:0] w_pld(input int r, input int tag, input int b);
        return {8'(r), 8'(tag), 16'(b), 8'h5A};
    endfunction

    task automatic add_burst(input int r, input int tag, input int n);
        aw_src[r].push_back(aw_pld(r, tag, n));
        for (int b = 0; b < n; b++) w_src[r].push_back({(b == n - 1), w_pld(r, tag, b)});
    endtask

    task automatic expect_burst(input int r, input int tag, input int n);
        exp_aw.push_back(aw_pld(r, tag, n));
        for (int b = 0; b < n; b++) exp_w.push_back({IW'(r), (b == n - 1), w_pld(r, tag, b)});
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_settle();
        for (int i = 0; i < NB; i++) begin
            bus.s_awvalid[i] = aw_en[i] && (aw_src[i].size() != 0);
            bus.s_awpld[i*AWW +: AWW] = '0;
            if (bus.s_awvalid[i]) bus.s_awpld[i*AWW +: AWW] = aw_src[i][0];
            bus.s_wvalid[i] = w_en[i] && (w_src[i].size() != 0);
            bus.s_wlast[i]  = 1'b0;
            bus.s_wpld[i*WW +: WW] = '0;
            if (bus.s_wvalid[i]) begin
                bus.s_wlast[i]         = w_src[i][0][WW];
                bus.s_wpld[i*WW +: WW] = w_src[i][0][WW-1:0];
            end
        end
        #1;
    endtask

    // Scores handshakes that will complete at the coming edge, then advances.
    task automatic finish_cyc();
        logic [AWW-1:0] ea;
        logic [EW-1:0]  ew;
        if (bus.m_awvalid && bus.m_awready) begin
            aw_hs_cnt++;
            vectors++;
            assert (exp_aw.size() != 0) else begin
                errors++;
                $error("FAIL aw_unexpected: observed %0h expected none", bus.m_awpld);
            end
            if (exp_aw.size() != 0) begin
                ea = exp_aw.pop_front();
                chk("aw_pld", 64'(bus.m_awpld), 64'(ea));
            end
        end
        if (bus.m_wvalid && bus.m_wready) begin
            vectors++;
            assert (exp_w.size() != 0) else begin
                errors++;
                $error("FAIL w_unexpected: observed %0h expected none", bus.m_wpld);
            end
            if (exp_w.size() != 0) begin
                ew = exp_w.pop_front();
                chk("w_beat", 64'({bus.m_wsel, bus.m_wlast, bus.m_wpld}), 64'(ew));
            end
        end
        for (int i = 0; i < NB; i++) begin
            if (bus.s_awvalid[i] && bus.s_awready[i]) void'(aw_src[i].pop_front());
            if (bus.s_wvalid[i] && bus.s_wready[i]) void'(w_src[i].pop_front());
        end
        @(negedge aclk);
    endtask

    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            drive_settle();
            finish_cyc();
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((exp_aw.size() != 0 || exp_w.size() != 0) && n < budget) begin
            cyc(1);
            n++;
        end
        vectors++;
        assert (exp_aw.size() == 0 && exp_w.size() == 0) else begin
            errors++;
            $error("FAIL drain_timeout: observed %0d aw / %0d w pending expected 0",
                   exp_aw.size(), exp_w.size());
        end
    endtask

    task automatic srst_pulse();
        srst = 1'b1;
        cyc(1);
        srst = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_m_awvalid"}, 64'(bus.m_awvalid), 64'd0);
        chk({tag, "_m_wvalid"},  64'(bus.m_wvalid),  64'd0);
        chk({tag, "_s_awready"}, 64'(bus.s_awready), 64'd0);
        chk({tag, "_s_wready"},  64'(bus.s_wready),  64'd0);
        chk({tag, "_m_wlast"},   64'(bus.m_wlast),   64'd0);
        chk({tag, "_m_wsel"},    64'(bus.m_wsel),    64'd0);
    endtask

    initial begin
        aresetn       = 1'b0;
        srst          = 1'b0;
        aw_en         = '0;
        w_en          = '0;
        bus.m_awready = 1'b1;
        bus.m_wready  = 1'b1;
        bus.s_awvalid = '0;
        bus.s_awpld   = '0;
        bus.s_wvalid  = '0;
        bus.s_wlast   = '0;
        bus.s_wpld    = '0;

        // Reset state
        @(negedge aclk);
        drive_settle();
        chk_idle_outputs("reset");
        finish_cyc();
        aresetn = 1'b1;
        cyc(1);

        // Single requester 2, 4-beat burst: same-cycle AW, W from next cycle
        aw_en = '1;
        w_en  = '1;
        add_burst(2, 1, 4);
        expect_burst(2, 1, 4);
        drive_settle();
        chk("t1_m_awvalid", 64'(bus.m_awvalid), 64'd1);
        chk("t1_s_awready", 64'(bus.s_awready), 64'b0100);
        chk("t1_no_passthru", 64'(bus.m_wvalid), 64'd0);
        finish_cyc();
        drive_settle();
        chk("t1_first_beat", 64'(bus.m_wvalid), 64'd1);
        chk("t1_m_wsel", 64'(bus.m_wsel), 64'd2);
        finish_cyc();
        wait_idle(20);

        // Pointer now 3: requester 3 wins over 2
        add_burst(2, 2, 1);
        add_burst(3, 2, 1);
        expect_burst(3, 2, 1);
        expect_burst(2, 2, 1);
        wait_idle(20);

        // All four requesting, single-beat bursts: order 0,1,2,3,0
        srst_pulse();
        drive_settle();
        chk_idle_outputs("srst");
        finish_cyc();
        for (int r = 0; r < NB; r++) add_burst(r, 3, 1);
        add_burst(0, 4, 1);
        for (int r = 0; r < NB; r++) expect_burst(r, 3, 1);
        expect_burst(0, 4, 1);
        drive_settle();
        chk("t2_first_grant", 64'(bus.s_awready), 64'b0001);
        finish_cyc();
        wait_idle(30);

        // Grant lock under backpressure
        srst_pulse();
        bus.m_awready = 1'b0;
        aw_en = 4'b0010;
        add_burst(1, 5, 1);
        add_burst(0, 5, 1);
        expect_burst(1, 5, 1);
        expect_burst(0, 5, 1);
        drive_settle();
        chk("t3_valid", 64'(bus.m_awvalid), 64'd1);
        chk("t3_pld_c1", 64'(bus.m_awpld), 64'(aw_pld(1, 5, 1)));
        finish_cyc();
        aw_en = 4'b0011;
        for (int k = 0; k < 2; k++) begin
            drive_settle();
            chk("t3_pld_locked", 64'(bus.m_awpld), 64'(aw_pld(1, 5, 1)));
            chk("t3_no_ready", 64'(bus.s_awready), 64'd0);
            finish_cyc();
        end
        bus.m_awready = 1'b1;
        drive_settle();
        chk("t3_grant1", 64'(bus.s_awready), 64'b0010);
        finish_cyc();
        drive_settle();
        chk("t3_grant0", 64'(bus.s_awready), 64'b0001);
        finish_cyc();
        aw_en = '1;
        wait_idle(20);

        // FIFO full: four AWs accepted, fifth only after a pop
        srst_pulse();
        bus.m_wready = 1'b0;
        aw_hs_cnt = 0;
        for (int r = 0; r < NB; r++) add_burst(r, 6, 1);
        add_burst(0, 7, 1);
        for (int r = 0; r < NB; r++) expect_burst(r, 6, 1);
        expect_burst(0, 7, 1);
        cyc(4);
        for (int k = 0; k < 3; k++) begin
            drive_settle();
            chk("t4_full_blocks", 64'(bus.m_awvalid), 64'd0);
            finish_cyc();
        end
        chk("t4_hs_count", 64'(aw_hs_cnt), 64'd4);
        bus.m_wready = 1'b1;
        drive_settle();
        chk("t4_pop_cycle_still_full", 64'(bus.m_awvalid), 64'd0);
        finish_cyc();
        bus.m_wready = 1'b0;
        drive_settle();
        chk("t4_unblocked", 64'(bus.m_awvalid), 64'd1);
        chk("t4_grant0", 64'(bus.s_awready), 64'b0001);
        finish_cyc();
        chk("t4_hs_count5", 64'(aw_hs_cnt), 64'd5);
        bus.m_wready = 1'b1;
        wait_idle(30);

        // Non-head W stalled while head waits mid-burst
        srst_pulse();
        aw_en = 4'b0001;
        w_en  = 4'b1001;
        add_burst(0, 8, 4);
        add_burst(3, 8, 2);
        expect_burst(0, 8, 4);
        expect_burst(3, 8, 2);
        drive_settle();
        chk("t5_empty_no_wready", 64'(bus.s_wready), 64'd0);
        finish_cyc();
        cyc(2);
        w_en  = 4'b1000;
        aw_en = 4'b1001;
        for (int k = 0; k < 2; k++) begin
            drive_settle();
            chk("t5_wait_state", 64'(bus.m_wvalid), 64'd0);
            chk("t5_s_wready", 64'(bus.s_wready), 64'b0001);
            chk("t5_m_wsel", 64'(bus.m_wsel), 64'd0);
            finish_cyc();
        end
        w_en = '1;
        wait_idle(20);

        // Async reset mid-burst, then clean restart with pointer at 0
        aw_en = '1;
        add_burst(1, 9, 4);
        expect_burst(1, 9, 4);
        cyc(3);
        drive_settle();
        chk("t6_beat2_valid", 64'(bus.m_wvalid), 64'd1);
        aresetn = 1'b0;
        #1;
        chk_idle_outputs("t6_rst");
        for (int r = 0; r < NB; r++) begin
            aw_src[r].delete();
            w_src[r].delete();
        end
        exp_aw.delete();
        exp_w.delete();
        finish_cyc();
        cyc(2);
        aresetn = 1'b1;
        w_src[2].push_back({1'b1, w_pld(2, 10, 0)});
        drive_settle();
        chk("t6_fifo_empty", 64'(bus.m_wvalid), 64'd0);
        chk("t6_no_wready", 64'(bus.s_wready), 64'd0);
        finish_cyc();
        w_src[2].delete();
        add_burst(3, 11, 2);
        add_burst(0, 11, 2);
        expect_burst(0, 11, 2);
        expect_burst(3, 11, 2);
        wait_idle(30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
